// File: rtl/adc_spi_master_tx_if.sv
// Frame request and SPI pin bundle for adc_spi_master_tx.
// Latency: none; this is a wiring bundle.
// Backpressure: i_send is ignored while o_busy is high.
interface adc_spi_master_tx_if;
    logic [15:0] i_data0;
    logic [15:0] i_data1;
    logic        i_send;
    logic        o_busy;
    logic        o_done;
    logic        o_SPI_CS;
    logic        o_SPI_clock;
    logic        o_SPI_data;

    modport master (
        output i_data0, i_data1, i_send,
        input  o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
    );

    modport slave (
        input  i_data0, i_data1, i_send,
        output o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
    );
endinterface

// File: rtl/adc_spi_master_tx.sv
// SPI master (CPOL=0/CPHA=0) sending {data0,data1} as one 32-bit MSB-first frame.
// Latency: CS low 1 cycle after accept; CS high at 1+CS_SETUP+63*CLK_DIV+CS_HOLD.
// Backpressure: i_send is only sampled while o_busy is low; requests during a frame are dropped.
module adc_spi_master_tx #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input logic               i_clock,
    input logic               i_reset,
    adc_spi_master_tx_if.slave bus
);
    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_C + 1 > 2) ? $clog2(MAX_C + 1) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      sreg_q, sreg_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_send) begin
                    sreg_d  = {bus.i_data0, bus.i_data1};
                    mosi_d  = bus.i_data0[15];
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SCK_HIGH;
                end
            end
            SCK_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    // Last bit skips the low phase; MOSI keeps bit0 through HOLD.
                    if (bit_q == 5'd31) begin
                        state_d = HOLD;
                    end else begin
                        sreg_d  = sreg_q << 1;
                        mosi_d  = sreg_q[30];
                        bit_d   = bit_q + 5'd1;
                        state_d = SCK_LOW;
                    end
                end
            end
            SCK_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SCK_HIGH;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d  = '0;
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                    if (CS_GAP == 0) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_SPI_CS    = cs_q;
    assign bus.o_SPI_clock = sck_q;
    assign bus.o_SPI_data  = mosi_q;
endmodule

// File: tb/tb_adc_spi_master_tx.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors decode the SPI pins and compare.
// Latency: n/a. Backpressure: frames are issued only once the DUT reports idle.
// DUT 0 uses default timing, DUT 1 the fastest legal timing.
module tb_adc_spi_master_tx;
    typedef struct {
        logic [31:0] data;
        int          accept;  // cycle in which i_send was presented
        int          len;     // CS-low cycle to CS-high cycle
        int          setup;   // CS-low cycle to first SCK rise
        int          gap;     // o_done cycle to busy-low cycle
        int          csgap;   // cycles CS high before this frame; 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   chks = 0;
    int   errs = 0;
    exp_t sb[2][$];

    adc_spi_master_tx_if ifa ();
    adc_spi_master_tx_if ifb ();

    adc_spi_master_tx u_a (.i_clock(clk), .i_reset(rst), .bus(ifa));
    adc_spi_master_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(0))
        u_b (.i_clock(clk), .i_reset(rst), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic m_cs[2], m_sck[2], m_mosi[2], m_done[2], m_busy[2];
    assign m_cs[0] = ifa.o_SPI_CS;    assign m_cs[1] = ifb.o_SPI_CS;
    assign m_sck[0] = ifa.o_SPI_clock; assign m_sck[1] = ifb.o_SPI_clock;
    assign m_mosi[0] = ifa.o_SPI_data; assign m_mosi[1] = ifb.o_SPI_data;
    assign m_done[0] = ifa.o_done;    assign m_done[1] = ifb.o_done;
    assign m_busy[0] = ifa.o_busy;    assign m_busy[1] = ifb.o_busy;

    task automatic check(input string name, input int got, input int exp);
        chks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        int          low_cyc = 0, rise_cyc = 0, first_rise = 0, rises = 0, done_cyc = 0;
        logic [31:0] word = '0;
        logic        pcs = 1'b1, psck = 1'b0, bad = 1'b0, wait_busy = 1'b0;
        exp_t        e;

        always @(negedge clk) begin
            if (pcs && !m_cs[g]) begin
                if (sb[g].size() > 0 && sb[g][0].csgap > 0)
                    check($sformatf("cs_high_gap_%0d", g), cyc - rise_cyc, sb[g][0].csgap);
                low_cyc = cyc; rises = 0; word = '0; bad = 1'b0;
            end
            if (!pcs && m_cs[g]) rise_cyc = cyc;
            if (m_sck[g] && m_cs[g]) bad = 1'b1;
            if (!psck && m_sck[g]) begin
                rises++;
                word = {word[30:0], m_mosi[g]};
                if (rises == 1) first_rise = cyc;
            end
            if (m_done[g]) begin
                if (sb[g].size() == 0) begin
                    chks++; errs++;
                    $display("FAIL unexpected_done_%0d got done=1 expected no frame", g);
                end else begin
                    e = sb[g].pop_front();
                    check($sformatf("data_%0d", g), int'(word), int'(e.data));
                    check($sformatf("sck_rises_%0d", g), rises, 32);
                    check($sformatf("done_with_cs_rise_%0d", g), int'({pcs, m_cs[g]}), 1);
                    check($sformatf("frame_len_%0d", g), cyc - low_cyc, e.len);
                    check($sformatf("setup_%0d", g), first_rise - low_cyc, e.setup);
                    check($sformatf("sck_high_while_cs_high_%0d", g), int'(bad), 0);
                    if (e.accept >= 0)
                        check($sformatf("accept_latency_%0d", g), low_cyc - e.accept, 1);
                    wait_busy = 1'b1;
                    done_cyc  = cyc;
                end
            end
            if (wait_busy && !m_busy[g]) begin
                check($sformatf("busy_gap_%0d", g), cyc - done_cyc, e.gap);
                wait_busy = 1'b0;
            end
            pcs  = m_cs[g];
            psck = m_sck[g];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int g, input logic [15:0] d0, input logic [15:0] d1, input logic s);
        if (g == 0) begin ifa.i_data0 = d0; ifa.i_data1 = d1; ifa.i_send = s; end
        else        begin ifb.i_data0 = d0; ifb.i_data1 = d1; ifb.i_send = s; end
    endtask

    task automatic send_frame(input int g, input logic [15:0] d0, input logic [15:0] d1,
                              input int len, input int setup, input int gap);
        exp_t e;
        e.data = {d0, d1}; e.accept = cyc; e.len = len; e.setup = setup; e.gap = gap; e.csgap = 0;
        sb[g].push_back(e);
        set_req(g, d0, d1, 1'b1);
        tick(1);
        set_req(g, d0, d1, 1'b0);
    endtask

    task automatic wait_idle(input int g, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!m_busy[g] && m_cs[g]) return;
        end
        chks++; errs++;
        $display("FAIL timeout_%0d got busy=%0b expected 0 within %0d cycles", g, m_busy[g], limit);
    endtask

    task automatic check_idle_pins(input int g, input string tag);
        check($sformatf("%s_cs_%0d", tag, g),   int'(m_cs[g]), 1);
        check($sformatf("%s_sck_%0d", tag, g),  int'(m_sck[g]), 0);
        check($sformatf("%s_mosi_%0d", tag, g), int'(m_mosi[g]), 0);
        check($sformatf("%s_busy_%0d", tag, g), int'(m_busy[g]), 0);
        check($sformatf("%s_done_%0d", tag, g), int'(m_done[g]), 0);
    endtask

    initial begin
        int   k;
        exp_t e;
        set_req(0, 16'h0, 16'h0, 1'b0);
        set_req(1, 16'h0, 16'h0, 1'b0);
        tick(3);
        check_idle_pins(0, "reset");
        check_idle_pins(1, "reset");
        rst = 1'b0;
        tick(2);

        // Default timing: CS high and o_done 260 cycles after CS low, busy low 4 later.
        send_frame(0, 16'h1234, 16'h5533, 260, 4, 4);
        wait_idle(0, 400);
        tick(3);

        send_frame(0, 16'd1000, 16'hA5A5, 260, 4, 4);
        wait_idle(0, 400);
        tick(3);

        // Requests and data changes mid-frame must not affect the frame in flight.
        k = cyc;
        send_frame(0, 16'hC3C3, 16'h0FF0, 260, 4, 4);
        tick(9);
        set_req(0, 16'hDEAD, 16'hBEEF, 1'b1);
        tick(1);
        set_req(0, 16'hDEAD, 16'hBEEF, 1'b0);
        tick(k + 200 - cyc);
        set_req(0, 16'hDEAD, 16'hBEEF, 1'b1);
        tick(1);
        set_req(0, 16'hDEAD, 16'hBEEF, 1'b0);
        wait_idle(0, 400);
        tick(20);

        // Held request: next frame is taken the cycle busy drops (265 after accept),
        // so CS stays high from the done cycle through that accept cycle: 5 cycles.
        k = cyc;
        for (int n = 0; n < 3; n++) begin
            e.data = 32'hBEEF0F0F; e.accept = k + n * 265; e.len = 260; e.setup = 4; e.gap = 4;
            e.csgap = (n == 0) ? 0 : 5;
            sb[0].push_back(e);
        end
        set_req(0, 16'hBEEF, 16'h0F0F, 1'b1);
        tick(531);
        set_req(0, 16'hBEEF, 16'h0F0F, 1'b0);
        wait_idle(0, 400);
        tick(10);

        // Reset mid-shift: pins return to idle next cycle, the frame produces no done.
        k = cyc;
        set_req(0, 16'hAAAA, 16'h5555, 1'b1);
        tick(1);
        set_req(0, 16'hAAAA, 16'h5555, 1'b0);
        tick(k + 100 - cyc);
        rst = 1'b1;
        tick(1);
        check_idle_pins(0, "midreset");
        rst = 1'b0;
        tick(5);
        send_frame(0, 16'h8001, 16'h7FFE, 260, 4, 4);
        wait_idle(0, 400);
        tick(5);

        // Minimum timing: CS high at t+66, busy drops together with done.
        send_frame(1, 16'hFFFF, 16'h0001, 65, 1, 0);
        wait_idle(1, 200);
        tick(5);

        check("pending_frames_0", sb[0].size(), 0);
        check("pending_frames_1", sb[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end
endmodule
